// File: rtl/alu_bist.sv
// Built-in self-test initiator for the 32-bit execute-stage ALU: drives directed then
// LFSR-generated vectors, checks alu_result against a golden model and records the first miss.
module alu_bist #(
    parameter int unsigned NUM_RAND = 64,
    parameter logic [31:0] SEED_A   = 32'h1ACE_B00C,
    parameter logic [31:0] SEED_B   = 32'h0BAD_F00D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alucontrol,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] fail_idx,
    output logic [31:0] fail_expect,
    output logic [31:0] fail_result
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  RUN      = 2'd1;
    localparam logic [1:0]  DONE     = 2'd2;
    localparam logic [15:0] LAST_IDX = 16'(7 + NUM_RAND - 1);

    logic [1:0]  state;
    logic [15:0] idx;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic [2:0]  rand_sel;

    logic [31:0] diff;
    logic [31:0] golden;
    logic        mismatch;
    logic [15:0] next_idx;
    logic [66:0] next_vec;
    logic [66:0] first_vec;

    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    endfunction

    // Packed as {a, b, op}.
    function automatic logic [66:0] directed_vec(input logic [2:0] sel);
        case (sel)
            3'd0:    return {32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b000};
            3'd1:    return {32'h1234_5678, 32'h8765_4321, 3'b001};
            3'd2:    return {32'd100,       32'd23,        3'b010};
            3'd3:    return {32'd50,        32'd75,        3'b110};
            3'd4:    return {32'd5,         32'd10,        3'b111};
            3'd5:    return {32'd20,        32'd10,        3'b111};
            default: return {32'h7FFF_FFFF, 32'h0000_0001, 3'b010};
        endcase
    endfunction

    function automatic logic [2:0] rand_op(input logic [2:0] sel);
        case (sel)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            3'd3:    return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // Golden ALU: SLT is just the sign bit of the wrapped difference.
    always_comb begin
        diff = alu_a - alu_b;
        case (alucontrol)
            3'b000:  golden = alu_a & alu_b;
            3'b001:  golden = alu_a | alu_b;
            3'b010:  golden = alu_a + alu_b;
            3'b110:  golden = diff;
            3'b111:  golden = {31'b0, diff[31]};
            default: golden = 32'h0;
        endcase
        mismatch = (alu_result != golden);
    end

    // The vector for idx+1 comes from the table below 7, otherwise from the live LFSR values.
    always_comb begin
        next_idx  = idx + 16'd1;
        first_vec = directed_vec(3'd0);
        if (next_idx < 16'd7) begin
            next_vec = directed_vec(next_idx[2:0]);
        end else begin
            next_vec = {lfsr_a, lfsr_b, rand_op(rand_sel)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 16'h0;
            lfsr_a      <= SEED_A;
            lfsr_b      <= SEED_B;
            rand_sel    <= 3'd0;
            alu_a       <= 32'h0;
            alu_b       <= 32'h0;
            alucontrol  <= 3'b000;
            err_count   <= 16'h0;
            fail_idx    <= 16'h0;
            fail_expect <= 32'h0;
            fail_result <= 32'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state                       <= RUN;
                        idx                         <= 16'h0;
                        lfsr_a                      <= SEED_A;
                        lfsr_b                      <= SEED_B;
                        rand_sel                    <= 3'd0;
                        {alu_a, alu_b, alucontrol}  <= first_vec;
                        err_count                   <= 16'h0;
                        fail_idx                    <= 16'h0;
                        fail_expect                 <= 32'h0;
                        fail_result                 <= 32'h0;
                    end
                end
                RUN: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        // A zero count means nothing has been captured yet.
                        if (err_count == 16'h0) begin
                            fail_idx    <= idx;
                            fail_expect <= golden;
                            fail_result <= alu_result;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state      <= DONE;
                        alu_a      <= 32'h0;
                        alu_b      <= 32'h0;
                        alucontrol <= 3'b000;
                    end else begin
                        idx                        <= next_idx;
                        {alu_a, alu_b, alucontrol} <= next_vec;
                        if (next_idx >= 16'd7) begin
                            lfsr_a   <= lfsr_step(lfsr_a);
                            lfsr_b   <= lfsr_step(lfsr_b);
                            rand_sel <= (rand_sel == 3'd4) ? 3'd0 : rand_sel + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'h0);

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: two instances (NUM_RAND=0 and 64) each drive a bench ALU;
// a vector-table model predicts every output each cycle, and directed tests pin literal values.
module tb_alu_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_sig   [2];
    logic        fault       [2];
    logic [31:0] alu_a       [2];
    logic [31:0] alu_b       [2];
    logic [2:0]  alu_ctl     [2];
    logic [31:0] alu_res     [2];
    logic        busy        [2];
    logic        done        [2];
    logic        pass        [2];
    logic [15:0] err_count   [2];
    logic [15:0] fail_idx    [2];
    logic [31:0] fail_expect [2];
    logic [31:0] fail_result [2];

    int checks   = 0;
    int failures = 0;
    logic check_en = 1'b0;

    // Vector table for a run of up to 71 vectors, built from the stated rules.
    logic [31:0] vec_a  [71];
    logic [31:0] vec_b  [71];
    logic [2:0]  vec_op [71];
    int total [2];

    // Model state: 0 idle, 1 running, 2 done.
    int          m_state    [2];
    int          m_pos      [2];
    int          m_err      [2];
    int          m_fail_idx [2];
    logic [31:0] m_fail_exp [2];
    logic [31:0] m_fail_res [2];

    logic [31:0] seen_a   [80];
    logic [31:0] seen_b   [80];
    logic [2:0]  seen_ctl [80];
    logic [31:0] seen_res [80];

    function automatic logic [31:0] golden_of(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [31:0] d;
        d = a - b;
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return d;
            3'b111:  return {31'b0, d[31]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] expected_at(input int p);
        return golden_of(vec_a[p], vec_b[p], vec_op[p]);
    endfunction

    function automatic logic [31:0] presented_at(input int d, input int p);
        return expected_at(p) | {31'b0, fault[d]};
    endfunction

    assign alu_res[0] = golden_of(alu_a[0], alu_b[0], alu_ctl[0]) | {31'b0, fault[0]};
    assign alu_res[1] = golden_of(alu_a[1], alu_b[1], alu_ctl[1]) | {31'b0, fault[1]};

    alu_bist #(.NUM_RAND(0)) dut_small (
        .clk(clk), .reset(reset), .start(start_sig[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alucontrol(alu_ctl[0]), .alu_result(alu_res[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
        .fail_idx(fail_idx[0]), .fail_expect(fail_expect[0]), .fail_result(fail_result[0])
    );

    alu_bist #(.NUM_RAND(64)) dut_big (
        .clk(clk), .reset(reset), .start(start_sig[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alucontrol(alu_ctl[1]), .alu_result(alu_res[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
        .fail_idx(fail_idx[1]), .fail_expect(fail_expect[1]), .fail_result(fail_result[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic build_vectors();
        logic [31:0] la;
        logic [31:0] lb;
        logic [2:0]  op_tab [5];
        op_tab = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        vec_a[0] = 32'hA5A5A5A5; vec_b[0] = 32'h5A5A5A5A; vec_op[0] = 3'b000;
        vec_a[1] = 32'h12345678; vec_b[1] = 32'h87654321; vec_op[1] = 3'b001;
        vec_a[2] = 32'd100;      vec_b[2] = 32'd23;       vec_op[2] = 3'b010;
        vec_a[3] = 32'd50;       vec_b[3] = 32'd75;       vec_op[3] = 3'b110;
        vec_a[4] = 32'd5;        vec_b[4] = 32'd10;       vec_op[4] = 3'b111;
        vec_a[5] = 32'd20;       vec_b[5] = 32'd10;       vec_op[5] = 3'b111;
        vec_a[6] = 32'h7FFFFFFF; vec_b[6] = 32'h00000001; vec_op[6] = 3'b010;
        la = 32'h1ACEB00C;
        lb = 32'h0BADF00D;
        for (int k = 0; k < 64; k++) begin
            vec_a[7 + k]  = la;
            vec_b[7 + k]  = lb;
            vec_op[7 + k] = op_tab[k % 5];
            la = {la[30:0], la[31] ^ la[21] ^ la[1] ^ la[0]};
            lb = {lb[30:0], lb[31] ^ lb[21] ^ lb[1] ^ lb[0]};
        end
        total[0] = 7;
        total[1] = 71;
    endtask

    // Model: walks the vector table once per start, tallying the misses the bench ALU makes.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_state[d]    <= 0;
                m_pos[d]      <= 0;
                m_err[d]      <= 0;
                m_fail_idx[d] <= 0;
                m_fail_exp[d] <= 32'h0;
                m_fail_res[d] <= 32'h0;
            end else if (m_state[d] == 1) begin
                if (presented_at(d, m_pos[d]) != expected_at(m_pos[d])) begin
                    m_err[d] <= m_err[d] + 1;
                    if (m_err[d] == 0) begin
                        m_fail_idx[d] <= m_pos[d];
                        m_fail_exp[d] <= expected_at(m_pos[d]);
                        m_fail_res[d] <= presented_at(d, m_pos[d]);
                    end
                end
                if (m_pos[d] == total[d] - 1) m_state[d] <= 2;
                else m_pos[d] <= m_pos[d] + 1;
            end else if (start_sig[d]) begin
                m_state[d]    <= 1;
                m_pos[d]      <= 0;
                m_err[d]      <= 0;
                m_fail_idx[d] <= 0;
                m_fail_exp[d] <= 32'h0;
                m_fail_res[d] <= 32'h0;
            end
        end
    end

    // Every output of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("dut%0d alu_a", d), alu_a[d],
                            (m_state[d] == 1) ? vec_a[m_pos[d]] : 32'h0);
                checkOutput($sformatf("dut%0d alu_b", d), alu_b[d],
                            (m_state[d] == 1) ? vec_b[m_pos[d]] : 32'h0);
                checkOutput($sformatf("dut%0d alucontrol", d), 32'(alu_ctl[d]),
                            (m_state[d] == 1) ? 32'(vec_op[m_pos[d]]) : 32'h0);
                checkOutput($sformatf("dut%0d busy", d), 32'(busy[d]), 32'(m_state[d] == 1));
                checkOutput($sformatf("dut%0d done", d), 32'(done[d]), 32'(m_state[d] == 2));
                checkOutput($sformatf("dut%0d pass", d), 32'(pass[d]),
                            32'(m_state[d] == 2 && m_err[d] == 0));
                checkOutput($sformatf("dut%0d err_count", d), 32'(err_count[d]), 32'(m_err[d]));
                checkOutput($sformatf("dut%0d fail_idx", d), 32'(fail_idx[d]), 32'(m_fail_idx[d]));
                checkOutput($sformatf("dut%0d fail_expect", d), fail_expect[d], m_fail_exp[d]);
                checkOutput($sformatf("dut%0d fail_result", d), fail_result[d], m_fail_res[d]);
            end
        end
    end

    // Returns at the first negedge of RUN (vector 0 on the outputs).
    task automatic applyStimulus(input int d);
        @(negedge clk);
        start_sig[d] = 1'b1;
        @(negedge clk);
        start_sig[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit, output int busy_cycles);
        busy_cycles = 0;
        for (int c = 0; c < limit && !done[d]; c++) begin
            if (busy[d]) begin
                if (busy_cycles < 80) begin
                    seen_a[busy_cycles]   = alu_a[d];
                    seen_b[busy_cycles]   = alu_b[d];
                    seen_ctl[busy_cycles] = alu_ctl[d];
                    seen_res[busy_cycles] = alu_res[d];
                end
                busy_cycles++;
            end
            @(negedge clk);
        end
        checkOutput($sformatf("dut%0d reaches done", d), 32'(done[d]), 32'd1);
    endtask

    initial begin
        int          n;
        logic [31:0] t1_res [7];
        t1_res = '{32'h0, 32'h97755779, 32'h7B, 32'hFFFFFFE7, 32'h1, 32'h0, 32'h80000000};
        build_vectors();
        reset = 1'b1;
        start_sig = '{1'b0, 1'b0};
        fault     = '{1'b0, 1'b0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset busy", 32'(busy[1]), 32'd0);
        checkOutput("reset alu_a", alu_a[1], 32'h0);
        reset = 1'b0;

        // T1: NUM_RAND=0 with a good ALU.
        applyStimulus(0);
        wait_done(0, 40, n);
        checkOutput("T1 busy cycles", 32'(n), 32'd7);
        for (int i = 0; i < 7; i++)
            checkOutput($sformatf("T1 result idx%0d", i), seen_res[i], t1_res[i]);
        checkOutput("T1 pass", 32'(pass[0]), 32'd1);
        checkOutput("T1 err_count", 32'(err_count[0]), 32'd0);

        // T2: result bit 0 stuck high.
        fault[0] = 1'b1;
        applyStimulus(0);
        wait_done(0, 40, n);
        checkOutput("T2 err_count", 32'(err_count[0]), 32'd3);
        checkOutput("T2 fail_idx", 32'(fail_idx[0]), 32'd0);
        checkOutput("T2 fail_expect", fail_expect[0], 32'h0);
        checkOutput("T2 fail_result", fail_result[0], 32'h1);
        checkOutput("T2 pass", 32'(pass[0]), 32'd0);

        // T5: start held high through part of RUN, then a restart from DONE.
        @(negedge clk);
        start_sig[0] = 1'b1;
        @(negedge clk);
        checkOutput("T5 idx0 a", alu_a[0], 32'hA5A5A5A5);
        @(negedge clk);
        checkOutput("T5 no restart a", alu_a[0], 32'h12345678);
        @(negedge clk);
        start_sig[0] = 1'b0;
        wait_done(0, 40, n);
        repeat (2) @(negedge clk);
        checkOutput("T5 done hold err_count", 32'(err_count[0]), 32'd3);
        start_sig[0] = 1'b1;
        @(negedge clk);
        start_sig[0] = 1'b0;
        checkOutput("T5 restart err_count", 32'(err_count[0]), 32'd0);
        checkOutput("T5 restart busy", 32'(busy[0]), 32'd1);
        checkOutput("T5 restart a", alu_a[0], 32'hA5A5A5A5);
        wait_done(0, 40, n);

        // T3: NUM_RAND=64 with a good ALU.
        applyStimulus(1);
        wait_done(1, 120, n);
        checkOutput("T3 busy cycles", 32'(n), 32'd71);
        checkOutput("T3 idx7 a", seen_a[7], 32'h1ACEB00C);
        checkOutput("T3 idx7 b", seen_b[7], 32'h0BADF00D);
        checkOutput("T3 idx7 op", 32'(seen_ctl[7]), 32'd0);
        checkOutput("T3 idx8 a", seen_a[8], 32'h359D6018);
        checkOutput("T3 idx8 b", seen_b[8], 32'h175BE01A);
        checkOutput("T3 idx8 op", 32'(seen_ctl[8]), 32'd1);
        checkOutput("T3 pass", 32'(pass[1]), 32'd1);

        // T4: reset in the middle of RUN.
        applyStimulus(1);
        repeat (3) @(negedge clk);
        checkOutput("T4 idx3 a", alu_a[1], 32'd50);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("T4 reset busy", 32'(busy[1]), 32'd0);
        checkOutput("T4 reset a", alu_a[1], 32'h0);
        checkOutput("T4 reset done", 32'(done[1]), 32'd0);
        applyStimulus(1);
        checkOutput("T4 replay a", alu_a[1], 32'hA5A5A5A5);
        wait_done(1, 120, n);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
